arb2_stream_sel: RTL and testbench

//  Clocked 2-input round-robin arbiter and output register that sits directly upstream of mux2x1.
//  Two valid/ready source channels compete for one output channel.

---
 rtl/arb2_stream_sel_pkg.sv | 23 ++
 rtl/arb2_stream_sel_grant.sv | 48 ++++
 rtl/arb2_stream_sel.sv | 113 +++++++++++
 tb/tb_arb2_stream_sel.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/arb2_stream_sel_pkg.sv
// Shared types and defaults for the 2-input round-robin stream arbiter.
// FSM state encodings, default sizing and the saturating counter width helper.
package arb2_stream_sel_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam int DEF_W         = 8;
   localparam int DEF_MAX_BURST = 4;

   typedef struct packed {
      logic vld;
      logic idx;
   } grant_t;

   // Counter must hold MAX_BURST itself so it can saturate there.
   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/arb2_stream_sel_grant.sv
// Combinational grant/ready logic for the 2-input arbiter.
// Readies never look at their own source's valid, only at the competitor's.
module arb2_grant
   import arb2_stream_sel_pkg::*;
#(
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CW        = cnt_w(MAX_BURST)
) (
   input  state_t          state,
   input  logic            owner,
   input  logic            ptr,
   input  logic [CW-1:0]   cnt,
   input  logic            i0_valid,
   input  logic            i1_valid,
   input  logic            adv,
   output logic            i0_ready,
   output logic            i1_ready,
   output grant_t          grant
);

   logic under_cap;
   logic acc0;
   logic acc1;

   assign under_cap = (cnt < CW'(MAX_BURST));

   always_comb begin
      i0_ready = 1'b0;
      i1_ready = 1'b0;
      if (state == ST_IDLE) begin
         i0_ready = adv && (!ptr || !i1_valid);
         i1_ready = adv && ( ptr || !i0_valid);
      end else if (!owner) begin
         // Owner keeps going until the cap, and past it only if unopposed.
         i0_ready = adv && (under_cap || !i1_valid);
         i1_ready = adv && (!i0_valid || !under_cap);
      end else begin
         i1_ready = adv && (under_cap || !i0_valid);
         i0_ready = adv && (!i1_valid || !under_cap);
      end
   end

   assign acc0      = i0_valid && i0_ready;
   assign acc1      = i1_valid && i1_ready;
   assign grant.vld = acc0 || acc1;
   assign grant.idx = acc1;

endmodule

// File: rtl/arb2_stream_sel.sv
// Round-robin 2:1 stream arbiter with bounded bursts and a registered output
// stage; s tracks the source of y_data and drives the downstream mux select.
module arb2_stream_sel
   import arb2_stream_sel_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i0_valid,
   input  logic [W-1:0] i0_data,
   output logic         i0_ready,
   input  logic         i1_valid,
   input  logic [W-1:0] i1_data,
   output logic         i1_ready,
   output logic         y_valid,
   output logic [W-1:0] y_data,
   input  logic         y_ready,
   output logic         s,
   output logic         busy
);

   localparam int            CW      = cnt_w(MAX_BURST);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_t        state, state_n;
   logic          owner, owner_n;
   logic          ptr, ptr_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          adv;
   grant_t        grant;

   assign adv  = !y_valid || y_ready;
   assign busy = (state == ST_BURST);

   arb2_grant #(
      .MAX_BURST (MAX_BURST),
      .CW        (CW)
   ) u_grant (
      .state    (state),
      .owner    (owner),
      .ptr      (ptr),
      .cnt      (cnt),
      .i0_valid (i0_valid),
      .i1_valid (i1_valid),
      .adv      (adv),
      .i0_ready (i0_ready),
      .i1_ready (i1_ready),
      .grant    (grant)
   );

   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (grant.vld) begin
               state_n = ST_BURST;
               owner_n = grant.idx;
               cnt_n   = CNT_ONE;
            end
         end
         ST_BURST: begin
            if (grant.vld) begin
               if (grant.idx == owner) begin
                  cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
               end else begin
                  owner_n = grant.idx;
                  cnt_n   = CNT_ONE;
               end
            end else if (adv && !i0_valid && !i1_valid) begin
               // Hand priority to the other side on the next contention.
               state_n = ST_IDLE;
               ptr_n   = ~owner;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         owner <= 1'b0;
         ptr   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         owner <= owner_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         s       <= 1'b0;
      end else if (adv) begin
         y_valid <= grant.vld;
         if (grant.vld) begin
            y_data <= grant.idx ? i1_data : i0_data;
            s      <= grant.idx;
         end
      end
   end

endmodule

// File: tb/tb_arb2_stream_sel.sv
// Directed + random bench for arb2_stream_sel against a beat-level model of
// who wins each accepted beat (run length per owner, round-robin on idle).
module tb_arb2_stream_sel;

   localparam int W  = 8;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i0_valid = 1'b0, i1_valid = 1'b0, y_ready = 1'b0;
   logic [W-1:0] i0_data = '0, i1_data = '0;
   logic         i0_ready, i1_ready, y_valid, s, busy;
   logic [W-1:0] y_data;

   int total = 0;
   int bad   = 0;

   // model state
   bit         m_busy;
   int         m_owner, m_streak, m_ptr;
   bit         m_yv;
   logic [7:0] m_yd;
   bit         m_s;

   arb2_stream_sel #(.W(W), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
      .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
      .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
      .s(s), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_streak = 0; m_ptr = 0;
      m_yv = 0; m_yd = 8'h00; m_s = 0;
   endtask

   // Which source gets the next beat given these valids; -1 if none.
   function automatic int who_wins(input bit v0, input bit v1);
      int o, p;
      bit vo, vp;
      if (!v0 && !v1) return -1;
      if (!m_busy) return (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
      o  = m_owner;
      p  = 1 - o;
      vo = (o == 0) ? v0 : v1;
      vp = (p == 0) ? v0 : v1;
      if (vo && (m_streak < MB || !vp)) return o;
      return p;
   endfunction

   task automatic step(input bit v0, input logic [7:0] d0, input bit v1,
                       input logic [7:0] d1, input bit yr);
      bit adv;
      int w;
      @(negedge clk);
      i0_valid = v0; i0_data = d0; i1_valid = v1; i1_data = d1; y_ready = yr;
      #1;
      adv = !m_yv || yr;
      chk("i0_ready", 32'(i0_ready), 32'(adv && who_wins(1'b1, v1) == 0));
      chk("i1_ready", 32'(i1_ready), 32'(adv && who_wins(v0, 1'b1) == 1));
      if (adv) begin
         w = who_wins(v0, v1);
         if (w >= 0) begin
            m_yv = 1;
            m_yd = (w == 1) ? d1 : d0;
            m_s  = (w == 1);
            if (m_busy && w == m_owner) m_streak++;
            else begin
               m_owner  = w;
               m_streak = 1;
            end
            m_busy = 1;
         end else begin
            m_yv = 0;
            if (m_busy) begin
               m_busy = 0;
               m_ptr  = 1 - m_owner;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("y_valid", 32'(y_valid), 32'(m_yv));
      chk("y_data",  32'(y_data),  32'(m_yd));
      chk("s",       32'(s),       32'(m_s));
      chk("busy",    32'(busy),    32'(m_busy));
   endtask

   task automatic do_reset();
      @(negedge clk);
      i0_valid = 0; i1_valid = 0; y_ready = 0;
      rst = 1;
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      bit s_exp[10];
      model_reset();
      // 1: reset values, then asynchronous reset mid-stream
      #1;
      chk("rst_y_valid", 32'(y_valid), 32'd0);
      chk("rst_y_data",  32'(y_data),  32'd0);
      chk("rst_s",       32'(s),       32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      @(negedge clk);
      rst = 0;
      step(1, 8'h3C, 0, 8'h00, 0);
      step(0, 8'h00, 1, 8'h77, 0);
      #2;
      rst = 1;
      i0_valid = 0; i1_valid = 0;
      #1;
      chk("arst_y_valid", 32'(y_valid), 32'd0);
      chk("arst_s",       32'(s),       32'd0);
      chk("arst_busy",    32'(busy),    32'd0);
      model_reset();
      @(negedge clk);
      rst = 0;
      step(1, 8'hA5, 0, 8'h00, 1);
      chk("t1_y_data", 32'(y_data), 32'hA5);
      chk("t1_s",      32'(s),      32'd0);

      // 2: i0 alone, back-to-back
      for (int i = 0; i < 6; i++) begin
         step(1, 8'(8'h11 + i), 0, 8'h00, 1);
         chk("t2_y_valid", 32'(y_valid), 32'd1);
         chk("t2_y_data",  32'(y_data),  32'(8'h11 + i));
         chk("t2_s",       32'(s),       32'd0);
      end

      // 3: both valid from fresh reset, bursts of MB alternate
      do_reset();
      s_exp = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
      for (int i = 0; i < 10; i++) begin
         step(1, 8'(8'h30 + i), 1, 8'(8'h50 + i), 1);
         chk("t3_s",    32'(s),    32'(s_exp[i]));
         chk("t3_busy", 32'(busy), 32'd1);
      end

      // 4: consumer stall with both sources valid, then resume
      for (int i = 0; i < 3; i++) step(1, 8'h61, 1, 8'h81, 0);
      for (int i = 0; i < 4; i++) step(1, 8'(8'h62 + i), 1, 8'(8'h82 + i), 1);

      // 5: i0 burst ends with one idle cycle, then simultaneous request
      step(1, 8'h90, 0, 8'h00, 1);
      step(1, 8'h91, 0, 8'h00, 1);
      step(0, 8'h00, 0, 8'h00, 1);
      chk("t5_busy_idle", 32'(busy), 32'd0);
      step(1, 8'h92, 1, 8'hB2, 1);
      chk("t5_s",      32'(s),      32'd1);
      chk("t5_y_data", 32'(y_data), 32'hB2);

      // 6: i0 takes over, sends 2, drops; i1 wins at once and holds 4
      step(1, 8'hC0, 0, 8'h00, 1);
      step(1, 8'hC1, 0, 8'h00, 1);
      chk("t6_owner0", 32'(s), 32'd0);
      step(0, 8'h00, 1, 8'hD0, 1);
      chk("t6_switch", 32'(s), 32'd1);
      for (int i = 1; i < 4; i++) begin
         step(1, 8'(8'hC2 + i), 1, 8'(8'hD0 + i), 1);
         chk("t6_hold", 32'(s), 32'd1);
      end
      step(1, 8'hC8, 1, 8'hD8, 1);
      chk("t6_yield", 32'(s), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
              8'($urandom), $urandom_range(0, 3) != 0);
         if (i % 97 == 50) step(0, 8'h00, 0, 8'h00, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
